ysyx_25040105_mdu: RTL and testbench
====================================

# ysyx_25040105_mdu

Iterative RV32M multiply/divide unit, parametrised in operand width, sitting beside the combinational EXU ALU in the execute stage. Accepts one operation per handshake, computes over multiple cycles with shift-add multiply and restoring divide, and holds the result until the consumer takes it. Divide-by-zero and signed overflow resolve on a single-cycle fast path. A flush aborts any in-flight operation.

## Interface
- XLEN, 32: operand and result width; even, 8..64.
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  abort in-flight op; highest priority.
- in_valid  input  1  operation request valid.
- in_ready  output  1  unit can accept a request (high only in IDLE and flush low).
- op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_data  input  XLEN  operand A (multiplicand / dividend).
- rs2_data  input  XLEN  operand B (multiplier / divisor).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  XLEN  result; 0 whenever out_valid low.

## Operation
- States: IDLE, CALC, DONE. Reset: state IDLE, in_ready 1, out_valid 0, result 0, counter 0.
- IDLE: on in_valid && in_ready, latch op, compute operand signs, store absolute values for signed operands (DIV/REM: both signed; MULH: both signed; MULHSU: A signed only; MUL/MULHU/DIVU/REMU: unsigned). Go to CALC, or directly to DONE for fast-path cases.
- Fast path (divide ops only): B == 0 -> quotient all ones, remainder = A. DIV/REM with A = 0x80..0 and B = all ones -> quotient = A, remainder 0.
- CALC, multiply: 2*XLEN accumulator, one multiplier bit per cycle, XLEN cycles. Final: negate 2*XLEN product if sign = signA ^ signB (MULH), signA (MULHSU). MUL returns low XLEN bits, MULH* return high XLEN bits.
- CALC, divide: restoring, one quotient bit per cycle, XLEN cycles. Quotient negated if signA ^ signB (DIV); remainder negated if signA (REM).
- Sign correction happens in the last CALC cycle; the result register is written when entering DONE.
- DONE: out_valid 1, result stable until out_valid && out_ready, then IDLE with result cleared to 0.
- Flush in any state: next state IDLE, out_valid 0, result 0, counter 0; no request accepted in the flush cycle.
- All arithmetic is modulo 2^XLEN or 2^(2*XLEN); no exceptions raised.

## Timing
- Accept at edge T0. Normal op: out_valid high from T0 + XLEN + 1 (33 cycles for XLEN = 32). Fast path: out_valid high from T0 + 1.
- in_ready is low from the accept edge until the cycle after the result handshake, so there is no same-cycle accept-after-complete. Peak throughput is one op per XLEN + 2 cycles.
- out_valid, once high, is held with result constant under backpressure until out_ready or flush.
- Asynchronous reset mid-operation: all state drops immediately to reset values; the op is lost.

## Configuration
- YSYX_25040105_MDU_FAST_MUL_EN defined: multiply ops use a single-cycle combinational 2*XLEN product and go IDLE -> DONE, with out_valid at T0 + 1. Divide timing is unchanged.
- Undefined: multiply is iterative as above (XLEN + 1 latency). Results are bit-identical in both builds.

## Test plan
- MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB, out_valid at T0+33 (T0+1 with FAST_MUL).
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2.
- DIVU 5 / 0 -> 0xFFFFFFFF and REMU 5 / 0 -> 5, both at T0+1. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
- Backpressure: out_ready low 5 cycles after out_valid -> result and out_valid held, in_ready low; handshake, then in_ready high next cycle.
- Flush at T0+10 of a DIV -> in_ready high the next cycle, out_valid never asserts, and a following MUL 3 x 4 returns 12.

Source files
------------

// File: rtl/ysyx_25040105_mdu.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one-cycle fast path
// for divide-by-zero and signed overflow. Define YSYX_25040105_MDU_FAST_MUL_EN for single-cycle multiply.
module ysyx_25040105_mdu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   oper_q, oper_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic              sign_a_in, sign_b_in, div_zero, div_ovf;
  logic [XLEN-1:0]   abs_a, abs_b, fast_res;

  always_comb begin
    sign_a_in = rs1_data[XLEN-1] & (op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM);
    sign_b_in = rs2_data[XLEN-1] & (op == OP_MULH || op == OP_DIV || op == OP_REM);
    abs_a     = sign_a_in ? -rs1_data : rs1_data;
    abs_b     = sign_b_in ? -rs2_data : rs2_data;
    div_zero  = op[2] && (rs2_data == '0);
    div_ovf   = (op == OP_DIV || op == OP_REM) &&
                (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
    if (div_zero) fast_res = op[1] ? rs1_data : '1;
    else          fast_res = op[1] ? '0 : rs1_data;
  end

  // Multiply keeps {partial_hi, multiplier}; divide keeps {remainder, dividend/quotient}.
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] mul_next, div_next, prod;
  logic [XLEN-1:0]   quo, rem, calc_res;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, oper_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, oper_q};
    div_ge    = ~div_diff[XLEN];
    div_next  = {div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0], acc_q[XLEN-2:0], div_ge};
    prod      = (sign_a_q ^ sign_b_q) ? -mul_next : mul_next;
    quo       = (sign_a_q ^ sign_b_q) ? -div_next[XLEN-1:0] : div_next[XLEN-1:0];
    rem       = sign_a_q ? -div_next[2*XLEN-1:XLEN] : div_next[2*XLEN-1:XLEN];
    if (op_q[2]) calc_res = op_q[1] ? rem : quo;
    else         calc_res = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

`ifdef YSYX_25040105_MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_mag, fast_prod;
  logic [XLEN-1:0]   fast_mul_res;

  always_comb begin
    fast_mag     = {{XLEN{1'b0}}, abs_a} * {{XLEN{1'b0}}, abs_b};
    fast_prod    = (sign_a_in ^ sign_b_in) ? -fast_mag : fast_mag;
    fast_mul_res = (op == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
  end
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    acc_d     = acc_q;
    oper_d    = oper_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    in_ready  = (state_q == IDLE) && !flush;
    out_valid = (state_q == DONE);
    if (flush) begin
      state_d  = IDLE;
      result_d = '0;
      cnt_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_d     = op;
            sign_a_d = sign_a_in;
            sign_b_d = sign_b_in;
            cnt_d    = '0;
            if (op[2]) begin
              acc_d  = {{XLEN{1'b0}}, abs_a};
              oper_d = abs_b;
            end else begin
              acc_d  = {{XLEN{1'b0}}, abs_b};
              oper_d = abs_a;
            end
            if (div_zero || div_ovf) begin
              state_d  = DONE;
              result_d = fast_res;
            end
`ifdef YSYX_25040105_MDU_FAST_MUL_EN
            else if (!op[2]) begin
              state_d  = DONE;
              result_d = fast_mul_res;
            end
`endif
            else begin
              state_d = CALC;
            end
          end
        end
        CALC: begin
          acc_d = op_q[2] ? div_next : mul_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(XLEN-1)) begin
            state_d  = DONE;
            result_d = calc_res;
            cnt_d    = '0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d  = IDLE;
            result_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      acc_q    <= '0;
      oper_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      acc_q    <= acc_d;
      oper_q   <= oper_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_ysyx_25040105_mdu.sv
// Scoreboard bench for ysyx_25040105_mdu: arithmetic reference model, decoupled monitor,
// latency, backpressure, flush and reset checks.
module tb_ysyx_25040105_mdu;
  localparam int XLEN     = 32;
  localparam int NORM_LAT = XLEN + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs1_data = 32'd0;
  logic [31:0] rs2_data = 32'd0;
  logic        in_ready, out_valid;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   fails = 0;
  int   ncyc = 0;
  int   t_acc = 0;
  bit   busy = 0, seen_valid = 0, prev_hs = 0, prev_flush = 0;
  bit   rand_ready = 0, ready_force = 1;

  ysyx_25040105_mdu #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference results straight from the RV32M definitions using 64-bit integer arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint    sa = longint'($signed(a));
    longint    sb = longint'($signed(b));
    longint    ua = longint'({32'd0, a});
    longint    ub = longint'({32'd0, b});
    int        ia = $signed(a);
    int        ib = $signed(b);
    bit        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    logic [63:0] p;
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return 32'(ia / ib);
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        return 32'(ia % ib);
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic bit isFast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef YSYX_25040105_MDU_FAST_MUL_EN
    if (!f[2]) return 1'b1;
`endif
    if (f[2] && b == 0) return 1'b1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
    return 1'b0;
  endfunction

  task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                               input string name);
    exp_t e;
    int   n = 0;
    while ((!in_ready || busy) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) begin
      checks++;
      fails++;
      $display("[TB] FAIL %s: in_ready timeout got 0 expected 1", name);
      return;
    end
    e.res  = model(f, a, b);
    e.lat  = isFast(f, a, b) ? 1 : NORM_LAT;
    e.name = name;
    sb_q.push_back(e);
    op       = f;
    rs1_data = a;
    rs2_data = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDone();
    int n = 0;
    while ((busy || sb_q.size() > 0) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) begin
      checks++;
      fails++;
      $display("[TB] FAIL completion timeout: got busy expected idle");
      sb_q.delete();
    end
  endtask

  always @(posedge clk) begin
    #1;
    out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  // Monitor: tracks acceptance, checks latency, result and handshake rules against the scoreboard.
  always @(negedge clk) begin
    ncyc++;
    if (!rst_n) begin
      busy = 0; seen_valid = 0; prev_hs = 0; prev_flush = 0;
      sb_q.delete();
    end else begin
      if (prev_hs || prev_flush) begin
        checkOutput(prev_flush ? "in_ready_after_flush" : "in_ready_after_handshake",
                    32'(in_ready), 32'(!flush));
        if (prev_flush) checkOutput("out_valid_after_flush", 32'(out_valid), 32'd0);
        prev_hs = 0;
        prev_flush = 0;
      end
      if (!out_valid) checkOutput("result_zero_when_invalid", result, 32'd0);
      if (busy) begin
        checkOutput("in_ready_low_while_busy", 32'(in_ready), 32'd0);
        if (flush) begin
          if (sb_q.size() > 0) void'(sb_q.pop_front());
          busy = 0; seen_valid = 0; prev_flush = 1;
        end else if (out_valid) begin
          if (sb_q.size() == 0) begin
            checkOutput("out_valid_without_request", 32'(out_valid), 32'd0);
          end else begin
            if (!seen_valid) begin
              seen_valid = 1;
              checkOutput({"latency ", sb_q[0].name}, 32'(ncyc - t_acc), 32'(sb_q[0].lat));
            end
            checkOutput({"result ", sb_q[0].name}, result, sb_q[0].res);
            if (out_ready) begin
              void'(sb_q.pop_front());
              busy = 0; seen_valid = 0; prev_hs = 1;
            end
          end
        end
      end else begin
        checkOutput("out_valid_while_idle", 32'(out_valid), 32'd0);
        if (in_valid && in_ready) begin
          busy = 1;
          t_acc = ncyc;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    int          sel;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset result", result, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(3'd0, 32'd7,          32'hFFFF_FFFD, "MUL 7*-3");
    applyStimulus(3'd1, 32'h8000_0000, 32'h8000_0000, "MULH min*min");
    applyStimulus(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULHU max*max");
    applyStimulus(3'd2, 32'hFFFF_FFFF, 32'd2,          "MULHSU -1*2");
    applyStimulus(3'd4, 32'hFFFF_FFF9, 32'd2,          "DIV -7/2");
    applyStimulus(3'd6, 32'hFFFF_FFF9, 32'd2,          "REM -7%2");
    applyStimulus(3'd5, 32'd100,        32'd7,          "DIVU 100/7");
    applyStimulus(3'd7, 32'd100,        32'd7,          "REMU 100%7");
    applyStimulus(3'd5, 32'd5,          32'd0,          "DIVU 5/0");
    applyStimulus(3'd7, 32'd5,          32'd0,          "REMU 5%0");
    applyStimulus(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "DIV ovf");
    applyStimulus(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "REM ovf");
    waitDone();

    // Backpressure: hold out_ready low for 5 cycles after out_valid.
    ready_force = 1'b0;
    applyStimulus(3'd5, 32'd100, 32'd7, "DIVU backpressure");
    for (int i = 0; i < 100 && !out_valid; i++) begin
      @(posedge clk); #1;
    end
    repeat (5) begin
      @(posedge clk); #1;
    end
    ready_force = 1'b1;
    waitDone();

    // Flush ten cycles into a divide, then a multiply must still work.
    applyStimulus(3'd4, 32'h1234_5678, 32'h11, "DIV flushed");
    repeat (10) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    applyStimulus(3'd0, 32'd3, 32'd4, "MUL 3*4 after flush");
    waitDone();

    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      f   = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = 32'($urandom_range(1, 15));
      else if (sel == 3) a = 32'($urandom_range(0, 15));
      applyStimulus(f, a, b, $sformatf("rand%0d op%0d", i, f));
    end
    waitDone();
    rand_ready = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset in the middle of an operation drops it immediately.
    applyStimulus(3'd5, 32'hDEAD_BEEF, 32'd3, "DIVU reset");
    repeat (5) begin
      @(posedge clk); #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("async reset out_valid", 32'(out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(3'd1, 32'hFFFF_FFFE, 32'd3, "MULH after reset");
    waitDone();

    checkOutput("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
